icache_resp: RTL and testbench
==============================

// Module: icache_resp
// PURPOSE
//  Instruction-cache responder on the fetch side of the ic_enable/iaddr/idata/ic_done interface.
//  Direct-mapped, 64-byte lines, read-only. A fetch request that hits returns the whole line;
//  a miss first fills the line from the memory bus in 8 x 64-bit beats.
//  Sits between the instruction-fetch unit and the system memory bus.
// PARAMETERS
//  SETS        64   number of lines; power of two >= 2; IDX_W = $clog2(SETS)
//  LINE_BYTES  64   line size in bytes; fixed, 8 beats of 8 bytes each
// PORTS
//  clk          in   1    clock; all logic on posedge
//  reset        in   1    synchronous, active-high
//  ic_enable    in   1    fetch request level; a request is a 0->1 edge
//  iaddr        in   64   fetch address; bits [5:0] ignored
//  ic_flush     in   1    invalidate all lines
//  idata        out  512  line data; byte i at idata[i*8+:8]; valid only while ic_done=1
//  ic_done      out  1    one-cycle pulse: the request has completed
//  mem_reqcyc   out  1    memory read request valid
//  mem_req      out  64   line address, {tag,idx,6'b0}
//  mem_reqtag   out  13   {1'b1 READ, 4'h1 MEMORY, 8'h00}; constant
//  mem_reqack   in   1    memory accepted request
//  mem_respcyc  in   1    response beat valid
//  mem_resp     in   64   response beat data, little-endian bytes
//  mem_respack  out  1    = mem_respcyc, combinational; beats are always accepted
// BEHAVIOUR
//  Address split: idx = iaddr[6+IDX_W-1:6], tag = iaddr[63:6+IDX_W].
//  Reset values: ic_done=0, idata=0, mem_reqcyc=0, mem_req=0, all valid bits=0, state=IDLE, en_q=0.
//  Data/tag arrays are not reset.
//  Request detect: req = ic_enable & ~en_q, where en_q is ic_enable registered.
//    Accepted only in IDLE; req in any other state is dropped, not queued.
//    A level held high for several cycles is exactly one request.
//  Each accepted request produces exactly one ic_done pulse unless reset intervenes.
//  States:
//   IDLE:   on req latch line address -> LOOKUP.
//           Else if ic_flush or flush_pend: clear all valid bits and flush_pend.
//   LOOKUP: read tag/valid/data at idx.
//           hit  -> RESPOND
//           miss -> MREQ, with mem_reqcyc=1 and mem_req=line address
//   MREQ:   hold mem_reqcyc and mem_req stable until mem_reqack is sampled 1.
//           Then drop mem_reqcyc, beat=0 -> FILL.
//   FILL:   each cycle with mem_respcyc: fill_buf[beat*64+:64] <= mem_resp, beat++.
//           On beat 7: write line, tag, valid=1 into the arrays -> RESPOND.
//           Cycles without mem_respcyc stall; there is no timeout.
//   RESPOND: ic_done=1 for one cycle; idata = line (hit) or fill_buf (miss) -> IDLE.
//  Latency, req sampled at edge N:
//   hit:  ic_done high in cycle N+2
//   miss: mem_reqcyc rises at N+2; ic_done is high the cycle after the 8th beat is sampled.
//  ic_flush while not IDLE: sets flush_pend; the clear happens in the first IDLE cycle.
//    An in-flight fill still completes and returns its data before the clear.
//  ic_flush and req in the same IDLE cycle: req is accepted, the flush is deferred.
//    The request looks up pre-flush contents.
//  mem_respcyc outside FILL: acked and discarded; no state change.
//  Reset mid-operation, any state: return to IDLE, no ic_done.
//    Partial fill is discarded; the line stays invalid.
//    Late beats are acked and dropped per the rule above.
//  Index wrap: lines with equal idx and different tag evict each other; no replacement choice.
// TESTING
//  1 Cold miss: reset; req at iaddr=0x1000
//    -> mem_req=0x1000 held until reqack.
//    -> beats 0x11..0x88 (beat k = 0x11*(k+1)) -> ic_done 1 cycle after beat 7.
//    -> idata[63:0]=0x11, idata[511:448]=0x88.
//  2 Hit: re-request 0x1023 -> no mem_reqcyc; ic_done at N+2 with the same 512-bit line as test 1.
//  3 Conflict (SETS=64): 0x1000, then 0x2000 (same idx=0) -> both miss.
//    Then 0x1000 again -> miss and refill.
//  4 Level hold: ic_enable high 3 cycles at 0x1000
//    -> exactly one ic_done, and no second request after it.
//  5 Reset during FILL after beat 4 -> ic_done never asserts.
//    Beats 5-7 acked and dropped; next req 0x1000 misses.
//  6 Flush during MREQ -> fill completes and ic_done returns data.
//    Following req to the same line misses.

Source files
------------

// File: rtl/icache_resp.sv
// Direct-mapped, read-only instruction cache responder: 64-byte lines, filled from the
// memory bus in eight 64-bit beats and returned whole on a single ic_done pulse.
module icache_resp #(
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ic_enable,
    input  logic [63:0]  iaddr,
    input  logic         ic_flush,
    output logic [511:0] idata,
    output logic         ic_done,
    output logic         mem_reqcyc,
    output logic [63:0]  mem_req,
    output logic [12:0]  mem_reqtag,
    input  logic         mem_reqack,
    input  logic         mem_respcyc,
    input  logic [63:0]  mem_resp,
    output logic         mem_respack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 58 - IDX_W;
    localparam logic [2:0] LAST_BEAT = 3'(LINE_BYTES / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MREQ,
        FILL,
        RESPOND
    } state_t;

    state_t             state;
    logic               en_q;
    logic               flush_pend;
    logic [57:0]        line_q;
    logic [2:0]         beat;
    logic [511:0]       fill_buf;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [511:0]       data_arr [SETS];

    logic               req;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_done;
    logic [511:0]       fill_line;
    logic               unused_offset;

    assign req           = ic_enable & ~en_q;
    assign idx           = line_q[IDX_W-1:0];
    assign tag           = line_q[57:IDX_W];
    assign hit           = valid[idx] && (tag_arr[idx] == tag);
    assign fill_done     = (state == FILL) && mem_respcyc && (beat == LAST_BEAT);
    assign fill_line     = {mem_resp, fill_buf[447:0]};
    assign mem_reqtag    = {1'b1, 4'h1, 8'h00};
    assign mem_respack   = mem_respcyc;
    assign unused_offset = ^iaddr[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            flush_pend <= 1'b0;
            valid      <= '0;
            ic_done    <= 1'b0;
            idata      <= '0;
            mem_reqcyc <= 1'b0;
            mem_req    <= '0;
            line_q     <= '0;
            beat       <= '0;
            fill_buf   <= '0;
        end else begin
            en_q    <= ic_enable;
            ic_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // a flush arriving with a request waits until the request is served
                        line_q <= iaddr[63:6];
                        state  <= LOOKUP;
                        if (ic_flush) flush_pend <= 1'b1;
                    end else if (ic_flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        idata   <= data_arr[idx];
                        ic_done <= 1'b1;
                        state   <= RESPOND;
                    end else begin
                        mem_reqcyc <= 1'b1;
                        mem_req    <= {line_q, 6'b0};
                        state      <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem_reqack) begin
                        mem_reqcyc <= 1'b0;
                        beat       <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (mem_respcyc) begin
                        fill_buf[{beat, 6'b0} +: 64] <= mem_resp;
                        beat <= beat + 3'd1;
                        if (beat == LAST_BEAT) begin
                            valid[idx] <= 1'b1;
                            idata      <= fill_line;
                            ic_done    <= 1'b1;
                            state      <= RESPOND;
                        end
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (ic_flush && state != IDLE) flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done && !reset) begin
            data_arr[idx] <= fill_line;
            tag_arr[idx]  <= tag;
        end
    end

endmodule

// File: tb/tb_icache_resp.sv
// Scoreboarded bench for icache_resp: a reference cache model predicts each returned line
// and whether the lookup hits; a scripted memory serves fills with programmable delays.
module tb_icache_resp;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_enable;
    logic [63:0]  iaddr;
    logic         ic_flush;
    logic [511:0] idata;
    logic         ic_done;
    logic         mem_reqcyc;
    logic [63:0]  mem_req;
    logic [12:0]  mem_reqtag;
    logic         mem_reqack;
    logic         mem_respcyc;
    logic [63:0]  mem_resp;
    logic         mem_respack;

    icache_resp #(.SETS(64), .LINE_BYTES(64)) dut (
        .clk(clk), .reset(reset), .ic_enable(ic_enable), .iaddr(iaddr),
        .ic_flush(ic_flush), .idata(idata), .ic_done(ic_done),
        .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqtag(mem_reqtag),
        .mem_reqack(mem_reqack), .mem_respcyc(mem_respcyc), .mem_resp(mem_resp),
        .mem_respack(mem_respack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [511:0] exp_q[$];

    bit           mvalid [64];
    logic [63:0]  mtag   [64];
    logic [511:0] mline  [64];

    int cyc;
    int hold_r;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [63:0] la, input int k);
        return 64'h11 * 64'(k + 1) + ((la ^ 64'h1000) << 8);
    endfunction

    function automatic logic [511:0] make_line(input logic [63:0] la);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_data(la, k);
        return l;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc >= hold_r) ic_enable = 1'b0;
        ic_flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ic_done) begin
            if (exp_q.size() == 0) check_eq("spurious_done", 1, 0);
            else check_eq("idata", idata, exp_q.pop_front());
        end
    end

    task automatic fetch(input logic [63:0] addr, input int hold, input int ack_dly,
                         input bit gaps, input bit flush_mreq, input bit flush_req,
                         input int abort_beat);
        logic [63:0]  la;
        int           idx;
        bit           hit;
        logic [511:0] line;
        la   = {addr[63:6], 6'b0};
        idx  = int'(addr[11:6]);
        hit  = mvalid[idx] && (mtag[idx] == la);
        line = hit ? mline[idx] : make_line(la);
        exp_q.push_back(line);

        iaddr     = addr;
        ic_enable = 1'b1;
        ic_flush  = flush_req;
        cyc       = 0;
        hold_r    = hold;
        step();
        check_eq("early_done", ic_done, 0);
        step();
        check_eq("lookup_done", ic_done, hit);
        check_eq("lookup_reqcyc", mem_reqcyc, !hit);
        if (!hit) begin
            check_eq("mem_req", mem_req, la);
            for (int i = 0; i < ack_dly; i++) begin
                if (i == 0 && flush_mreq) ic_flush = 1'b1;
                step();
            end
            check_eq("req_held", {mem_reqcyc, mem_req}, {1'b1, la});
            mem_reqack = 1'b1;
            step();
            mem_reqack = 1'b0;
            check_eq("reqcyc_drop", mem_reqcyc, 0);
            for (int k = 0; k < 8; k++) begin
                if (gaps && (k % 3 == 1)) begin
                    mem_respcyc = 1'b0;
                    step();
                end
                mem_respcyc = 1'b1;
                mem_resp    = beat_data(la, k);
                if (k == 0) check_eq("respack", mem_respack, 1);
                step();
                if (k == abort_beat) begin
                    mem_respcyc = 1'b0;
                    reset       = 1'b1;
                    void'(exp_q.pop_back());
                    step();
                    reset = 1'b0;
                    check_eq("abort_done", ic_done, 0);
                    check_eq("abort_reqcyc", mem_reqcyc, 0);
                    for (int j = k + 1; j < 8; j++) begin
                        mem_respcyc = 1'b1;
                        mem_resp    = beat_data(la, j);
                        check_eq("late_respack", mem_respack, 1);
                        step();
                    end
                    mem_respcyc = 1'b0;
                    clear_model();
                    ic_enable = 1'b0;
                    repeat (4) step();
                    return;
                end
            end
            mem_respcyc = 1'b0;
            check_eq("fill_done", ic_done, 1);
            mvalid[idx] = 1'b1;
            mtag[idx]   = la;
            mline[idx]  = line;
        end
        if (flush_mreq || flush_req) clear_model();
        repeat (4) step();
        ic_enable = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        reset = 1'b1; ic_enable = 1'b0; iaddr = '0; ic_flush = 1'b0;
        mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
        hold_r = 1; cyc = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check_eq("rst_done", ic_done, 0);
        check_eq("rst_idata", idata, 0);
        check_eq("rst_reqcyc", mem_reqcyc, 0);
        check_eq("rst_req", mem_req, 0);
        check_eq("reqtag", mem_reqtag, 13'h1100);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fetch(64'h1000, 1, 2, 0, 0, 0, -1);   // cold miss
        fetch(64'h1023, 1, 0, 0, 0, 0, -1);   // hit on same line
        fetch(64'h2000, 1, 0, 1, 0, 0, -1);   // conflict eviction, gapped beats
        fetch(64'h1000, 1, 3, 0, 0, 0, -1);   // refill after eviction

        mem_respcyc = 1'b1; mem_resp = 64'hdead;   // stray beat in IDLE
        check_eq("stray_respack", mem_respack, 1);
        @(negedge clk);
        mem_respcyc = 1'b0;
        repeat (2) @(negedge clk);

        fetch(64'h1000, 3, 0, 0, 0, 0, -1);   // level held 3 cycles
        repeat (6) @(negedge clk);
        fetch(64'h1040, 1, 1, 0, 0, 0, -1);   // separate set
        fetch(64'h3000, 1, 1, 0, 0, 0, 4);    // reset after beat 4
        fetch(64'h1000, 1, 1, 0, 0, 0, -1);   // misses after reset
        fetch(64'h1080, 1, 2, 0, 1, 0, -1);   // flush during MREQ
        fetch(64'h1080, 1, 1, 0, 0, 0, -1);   // misses after deferred flush
        fetch(64'h1080, 1, 0, 0, 0, 1, -1);   // flush with req: pre-flush hit
        fetch(64'h1080, 1, 0, 1, 0, 0, -1);   // then misses
        fetch(64'h10bf, 1, 0, 0, 0, 0, -1);   // hit, offset ignored

        ic_flush = 1'b1;                       // plain flush in IDLE
        @(negedge clk);
        ic_flush = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        fetch(64'h1080, 1, 0, 0, 0, 0, -1);

        repeat (5) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
